// File: rtl/countdown_alarm_timer.sv
// mm:ss countdown timer driven by the 1 ms tick, with alarm, ack and auto-stop timeout.
// Optional macro BUZZ_PATTERN_EN: 2 Hz beep pattern on buzz instead of a solid tone.
module countdown_alarm_timer #(
    parameter int TICKS_PER_SEC   = 1000,
    parameter int MAX_MIN         = 99,
    parameter int ALARM_TIMEOUT_S = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ms_tick,
    input  logic       load,
    input  logic [6:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    input  logic       ack,
    output logic [6:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       expired,
    output logic       expired_pulse,
    output logic       buzz,
    output logic       missed
);

    localparam int MS_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int AL_W = (ALARM_TIMEOUT_S > 1) ? $clog2(ALARM_TIMEOUT_S + 1) : 1;

    localparam logic [MS_W-1:0] MS_LAST = MS_W'(TICKS_PER_SEC - 1);
    localparam logic [MS_W-1:0] MS_ONE  = MS_W'(1);
    localparam logic [AL_W-1:0] AL_LAST = AL_W'(ALARM_TIMEOUT_S - 1);
    localparam logic [AL_W-1:0] AL_ONE  = AL_W'(1);
    localparam logic [6:0]      MIN_CAP = 7'(MAX_MIN);
    localparam logic [5:0]      SEC_CAP = 6'd59;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_ALARM = 2'd3;

    logic [1:0]      state, state_nxt;
    logic [6:0]      min_nxt;
    logic [5:0]      sec_nxt;
    logic [MS_W-1:0] ms_cnt, ms_nxt;
    logic [AL_W-1:0] alarm_cnt, alarm_nxt;
    logic            missed_nxt;
    logic            pulse_nxt;
    logic            buzz_nxt;

    logic [6:0] load_min_sat;
    logic [5:0] load_sec_sat;
    logic       nonzero;

    assign load_min_sat = (load_min > MIN_CAP) ? MIN_CAP : load_min;
    assign load_sec_sat = (load_sec > SEC_CAP) ? SEC_CAP : load_sec;
    assign nonzero      = (min != 7'd0) || (sec != 6'd0);

    // Only inputs meaningful in the current state compete; priority is ack > load > pause > start.
    always_comb begin
        state_nxt  = state;
        min_nxt    = min;
        sec_nxt    = sec;
        ms_nxt     = ms_cnt;
        alarm_nxt  = alarm_cnt;
        missed_nxt = missed;
        pulse_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (load) begin
                    min_nxt    = load_min_sat;
                    sec_nxt    = load_sec_sat;
                    ms_nxt     = '0;
                    missed_nxt = 1'b0;
                end else if (start && nonzero) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (pause) begin
                    state_nxt = S_PAUSE;
                end else if (ms_tick) begin
                    if (ms_cnt == MS_LAST) begin
                        ms_nxt = '0;
                        if (sec != 6'd0) begin
                            sec_nxt = sec - 6'd1;
                        end else begin
                            sec_nxt = SEC_CAP;
                            min_nxt = min - 7'd1;
                        end
                        // 00:01 is the only value that decrements to 00:00.
                        if (min == 7'd0 && sec == 6'd1) begin
                            state_nxt = S_ALARM;
                            pulse_nxt = 1'b1;
                            alarm_nxt = '0;
                        end
                    end else begin
                        ms_nxt = ms_cnt + MS_ONE;
                    end
                end
            end
            S_PAUSE: begin
                if (load) begin
                    min_nxt    = load_min_sat;
                    sec_nxt    = load_sec_sat;
                    ms_nxt     = '0;
                    missed_nxt = 1'b0;
                    state_nxt  = S_IDLE;
                end else if (start) begin
                    state_nxt = S_RUN;
                end
            end
            default: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                    ms_nxt    = '0;
                    alarm_nxt = '0;
                end else if (ms_tick) begin
                    if (ms_cnt == MS_LAST) begin
                        ms_nxt = '0;
                        if (alarm_cnt == AL_LAST) begin
                            state_nxt  = S_IDLE;
                            missed_nxt = 1'b1;
                            alarm_nxt  = '0;
                        end else begin
                            alarm_nxt = alarm_cnt + AL_ONE;
                        end
                    end else begin
                        ms_nxt = ms_cnt + MS_ONE;
                    end
                end
            end
        endcase
    end

`ifdef BUZZ_PATTERN_EN
    localparam logic [MS_W-1:0] Q1 = MS_W'(TICKS_PER_SEC / 4);
    localparam logic [MS_W-1:0] Q2 = MS_W'(TICKS_PER_SEC / 2);
    localparam logic [MS_W-1:0] Q3 = MS_W'((3 * TICKS_PER_SEC) / 4);

    logic [1:0] quarter;

    // Even quarters of each alarm second are the "on" half of the beep.
    always_comb begin
        quarter = 2'd0;
        if (ms_nxt >= Q3)      quarter = 2'd3;
        else if (ms_nxt >= Q2) quarter = 2'd2;
        else if (ms_nxt >= Q1) quarter = 2'd1;
    end

    assign buzz_nxt = (state_nxt == S_ALARM) && !quarter[0];
`else
    assign buzz_nxt = (state_nxt == S_ALARM);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            min           <= 7'd0;
            sec           <= 6'd0;
            ms_cnt        <= '0;
            alarm_cnt     <= '0;
            running       <= 1'b0;
            expired       <= 1'b0;
            expired_pulse <= 1'b0;
            buzz          <= 1'b0;
            missed        <= 1'b0;
        end else begin
            state         <= state_nxt;
            min           <= min_nxt;
            sec           <= sec_nxt;
            ms_cnt        <= ms_nxt;
            alarm_cnt     <= alarm_nxt;
            running       <= (state_nxt == S_RUN);
            expired       <= (state_nxt == S_ALARM);
            expired_pulse <= pulse_nxt;
            buzz          <= buzz_nxt;
            missed        <= missed_nxt;
        end
    end

endmodule

// File: tb/tb_countdown_alarm_timer.sv
// Directed bench for countdown_alarm_timer (default parameters); ms_tick held high to count one tick per cycle.
module tb_countdown_alarm_timer;

    logic       clk = 1'b0;
    logic       reset, ms_tick, load, start, pause, ack;
    logic [6:0] load_min;
    logic [5:0] load_sec;
    logic [6:0] min;
    logic [5:0] sec;
    logic       running, expired, expired_pulse, buzz, missed;

    int tests = 0;
    int fails = 0;

    countdown_alarm_timer dut (
        .clk(clk), .reset(reset), .ms_tick(ms_tick), .load(load),
        .load_min(load_min), .load_sec(load_sec), .start(start),
        .pause(pause), .ack(ack), .min(min), .sec(sec),
        .running(running), .expired(expired), .expired_pulse(expired_pulse),
        .buzz(buzz), .missed(missed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [6:0] m, input logic [5:0] s);
        load = 1'b1; load_min = m; load_sec = s;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1;
        step();
        pause = 1'b0;
    endtask

    task automatic ticks(input int n);
        ms_tick = 1'b1;
        repeat (n) step();
        ms_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ms_tick = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
        load_min = 7'd0; load_sec = 6'd0;
        step(); step();
        check("rst_min", min, 0);
        check("rst_sec", sec, 0);
        check("rst_flags", {running, expired, expired_pulse, buzz, missed}, 0);
        reset = 1'b0;

        // 00:03 down to expiry
        do_load(7'd0, 6'd3);
        check("t1_load_sec", sec, 3);
        check("t1_idle_run", running, 0);
        do_start();
        check("t1_running", running, 1);
        ticks(1000);
        check("t1_sec2", sec, 2);
        ticks(1000);
        check("t1_sec1", sec, 1);
        ticks(999);
        check("t1_sec1_late", sec, 1);
        check("t1_pulse_early", expired_pulse, 0);
        ticks(1);
        check("t1_sec0", sec, 0);
        check("t1_pulse", expired_pulse, 1);
        check("t1_expired", expired, 1);
        check("t1_buzz", buzz, 1);
        check("t1_not_running", running, 0);
        step();
        check("t1_pulse_one", expired_pulse, 0);
        check("t1_still_exp", expired, 1);
        // ack outranks load in the same cycle
        ack = 1'b1; load = 1'b1; load_min = 7'd5; load_sec = 6'd5;
        step();
        ack = 1'b0; load = 1'b0;
        check("t1_ack_exp", expired, 0);
        check("t1_ack_buzz", buzz, 0);
        check("t1_ack_noload", {min, sec}, 0);

        // 01:00 borrows a minute
        do_load(7'd1, 6'd0);
        do_start();
        ticks(1000);
        check("t2_min", min, 0);
        check("t2_sec", sec, 59);
        check("t2_running", running, 1);
        do_pause();
        check("t2_paused", running, 0);

        // pause holds ms_cnt
        do_load(7'd0, 6'd5);
        check("t3_load_sec", sec, 5);
        do_start();
        ticks(500);
        do_pause();
        check("t3_paused", running, 0);
        ticks(2000);
        check("t3_frozen", sec, 5);
        do_start();
        check("t3_resumed", running, 1);
        ticks(499);
        check("t3_sec5", sec, 5);
        ticks(1);
        check("t3_sec4", sec, 4);

        // alarm timeout without ack
        ticks(3999);
        check("t4_sec1", sec, 1);
        ticks(1);
        check("t4_expired", expired, 1);
        ticks(59999);
        check("t4_still_exp", expired, 1);
        check("t4_no_miss_yet", missed, 0);
        ticks(1);
        check("t4_timeout_exp", expired, 0);
        check("t4_missed", missed, 1);
        check("t4_buzz_off", buzz, 0);
        do_load(7'd0, 6'd10);
        check("t4_missed_clr", missed, 0);
        check("t4_sec10", sec, 10);

        // saturation and zero start
        do_load(7'd120, 6'd63);
        check("t5_min_sat", min, 99);
        check("t5_sec_sat", sec, 59);
        do_load(7'd0, 6'd0);
        do_start();
        check("t5_zero_start", running, 0);

        // pause + start + tick together: pause wins, tick dropped
        do_load(7'd0, 6'd2);
        do_start();
        ticks(10);
        pause = 1'b1; start = 1'b1; ms_tick = 1'b1;
        step();
        pause = 1'b0; start = 1'b0; ms_tick = 1'b0;
        check("t6_paused", running, 0);
        do_start();
        ticks(989);
        check("t6_drop_sec2", sec, 2);
        ticks(1);
        check("t6_drop_sec1", sec, 1);
        ticks(1000);
        check("t6_expired", expired, 1);
        check("t6_buzz0", buzz, 1);
        ticks(249);
        check("t6_buzz249", buzz, 1);
        ticks(1);
`ifdef BUZZ_PATTERN_EN
        check("t6_buzz250", buzz, 0);
`else
        check("t6_buzz250", buzz, 1);
`endif
        ticks(250);
        check("t6_buzz500", buzz, 1);
        ticks(250);
`ifdef BUZZ_PATTERN_EN
        check("t6_buzz750", buzz, 0);
`else
        check("t6_buzz750", buzz, 1);
`endif
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_rst_flags", {running, expired, expired_pulse, buzz, missed}, 0);
        check("t6_rst_time", {min, sec}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
